mcpu_mem_arbiter: RTL and testbench
===================================

# mcpu_mem_arbiter

Arbitrates the single-port 256-word MCPU RAM between two requesters: the CPU memory port (instruction fetch and load/store) and a debug/loader port used to load programs and inspect memory. It issues one RAM access per cycle, grants round-robin when both request, and routes read data back to the winner one cycle later. A debug lock holds the CPU off memory during program load. The block sits between the MCPU control/datapath and the RAM instance.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM address width (256 words)
- WORD_SIZE, 16, RAM word width
- CNT_WIDTH, 16, width of CPU wait-cycle counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- cpu_req  input  1  CPU access request, held until granted
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_WIDTH  CPU address
- cpu_wdata  input  WORD_SIZE  CPU write data
- cpu_gnt  output  1  CPU access issued this cycle
- cpu_rvalid  output  1  CPU read data valid
- cpu_rdata  output  WORD_SIZE  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/ADDR_WIDTH/WORD_SIZE  debug port, same meaning as CPU
- dbg_lock  input  1  while high, CPU is never granted
- dbg_gnt, dbg_rvalid, dbg_rdata  output  1/1/WORD_SIZE  debug grant, read valid, read data
- ram_en, ram_we  output  1  RAM enable / write enable
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_wdata  output  WORD_SIZE  RAM write data
- ram_rdata  input  WORD_SIZE  RAM synchronous read data (valid cycle after ram_en with ram_we=0)
- cpu_wait_cnt  output  CNT_WIDTH  saturating count of cycles with cpu_req=1 and cpu_gnt=0

## Operation
- State: last_winner (0=CPU, 1=DBG), rd_pending, rd_owner, cpu_wait_cnt.
- Eligibility: cpu_elig = cpu_req & ~dbg_lock; dbg_elig = dbg_req.
- Grant (combinational from state and requests): only one eligible -> that one; both -> the one not equal to last_winner; none -> no grant.
- On grant: ram_en=1, ram_we/addr/wdata from winner; last_winner updated at the clock edge. No grant: ram_en=0, ram_we=0, addr/wdata driven 0.
- Granted read: rd_pending<=1, rd_owner<=winner; else rd_pending<=0. Next cycle: owner's rvalid=1, rdata=ram_rdata; other port rvalid=0, rdata=0.
- Writes produce no rvalid.
- cpu_wait_cnt increments when cpu_req & ~cpu_gnt (including lock), saturates at all-ones.
- dbg_lock does not abort an in-flight CPU read; its rvalid still returns.
- Requesters keep req and payload stable until gnt; on gnt they may change next cycle (back-to-back grants allowed).

## Timing
- Reset values: last_winner=1 (CPU wins first tie), rd_pending=0, all gnt/rvalid/ram_en/ram_we=0, rdata=0, cpu_wait_cnt=0.
- Grant latency: 0 cycles (same cycle as request when uncontested); read data latency: 1 cycle after grant.
- Throughput: 1 access/cycle; under full contention grants strictly alternate.
- Reset asserted mid-read: pending rvalid is dropped, no rvalid after reset release.
- Simultaneous cpu_req and dbg_req with dbg_lock=1: DBG granted every cycle; last_winner still updated.

## Structure
- Shared MCPU package holds ADDR_WIDTH/WORD_SIZE defaults and the port-id constants (PORT_CPU=0, PORT_DBG=1).
- No sub-module needed; a single always block for state plus combinational grant logic. Optional sub-module mcpu_rr_pick2 for the two-way round-robin pick.

## Test plan
- After reset, cpu_req read addr 0x05 with RAM[5]=0x1234 -> cpu_gnt same cycle, cpu_rvalid=1, cpu_rdata=0x1234 next cycle; dbg outputs 0.
- CPU and DBG both request reads continuously for 6 cycles -> grants CPU,DBG,CPU,DBG,CPU,DBG; rvalid routed to matching owner each following cycle; cpu_wait_cnt=3.
- dbg_lock=1, DBG writes 0x3013 to addr 0x00..0x1C while cpu_req=1 -> only dbg_gnt, RAM contents match, cpu_wait_cnt equals locked cycles; drop lock -> CPU granted next cycle.
- CPU read granted, dbg_lock rises the following cycle -> CPU rvalid still delivered.
- Reset pulsed the cycle after a DBG read grant -> dbg_rvalid stays 0; all outputs at reset values.
- Force cpu_wait_cnt to 0xFFFE, hold CPU starved 3 cycles -> counter reads 0xFFFF, no wrap.

Source files
------------

// File: rtl/mcpu_mem_arbiter_pkg.sv
// rtl/mcpu_mem_arbiter_pkg.sv - shared MCPU widths and arbiter port identifiers
package mcpu_mem_arbiter_pkg;

    localparam int MCPU_ADDR_WIDTH = 8;
    localparam int MCPU_WORD_SIZE  = 16;
    localparam int MCPU_CNT_WIDTH  = 16;

    // Requester identity; also the encoding of last_winner and rd_owner.
    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    // The port that should win a tie after `p` won the previous access.
    function automatic port_e other_port(input port_e p);
        return (p == PORT_CPU) ? PORT_DBG : PORT_CPU;
    endfunction

endpackage

// File: rtl/mcpu_rr_pick2.sv
// rtl/mcpu_rr_pick2.sv - two-way round-robin pick between CPU and debug ports
module mcpu_rr_pick2
    import mcpu_mem_arbiter_pkg::*;
(
    input  logic  cpu_elig_i,
    input  logic  dbg_elig_i,
    input  port_e last_winner_i,
    output logic  gnt_valid_o,
    output port_e winner_o
);

    // A lone eligible port wins outright; a tie goes to the port that did not win last.
    always_comb begin
        gnt_valid_o = cpu_elig_i | dbg_elig_i;
        winner_o    = PORT_CPU;
        if (cpu_elig_i && dbg_elig_i) begin
            winner_o = other_port(last_winner_i);
        end else if (dbg_elig_i) begin
            winner_o = PORT_DBG;
        end
    end

endmodule

// File: rtl/mcpu_mem_arbiter.sv
// rtl/mcpu_mem_arbiter.sv - single-port MCPU RAM arbiter between CPU and debug loader
module mcpu_mem_arbiter
    import mcpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = MCPU_ADDR_WIDTH,
    parameter int WORD_SIZE  = MCPU_WORD_SIZE,
    parameter int CNT_WIDTH  = MCPU_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [WORD_SIZE-1:0]  cpu_rdata,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0]  dbg_wdata,
    input  logic                  dbg_lock,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [WORD_SIZE-1:0]  dbg_rdata,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_SIZE-1:0]  ram_wdata,
    input  logic [WORD_SIZE-1:0]  ram_rdata,

    output logic [CNT_WIDTH-1:0]  cpu_wait_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    port_e                last_winner_q, last_winner_d;
    logic                 rd_pending_q,  rd_pending_d;
    port_e                rd_owner_q,    rd_owner_d;
    logic [CNT_WIDTH-1:0] wait_cnt_q,    wait_cnt_d;

    logic  cpu_elig;
    logic  dbg_elig;
    logic  gnt_valid;
    port_e winner;
    logic  win_we;

    // The lock only removes the CPU from arbitration; it never cancels a read already issued.
    assign cpu_elig = cpu_req & ~dbg_lock;
    assign dbg_elig = dbg_req;

    mcpu_rr_pick2 u_pick (
        .cpu_elig_i    (cpu_elig),
        .dbg_elig_i    (dbg_elig),
        .last_winner_i (last_winner_q),
        .gnt_valid_o   (gnt_valid),
        .winner_o      (winner)
    );

    assign cpu_gnt = gnt_valid & (winner == PORT_CPU);
    assign dbg_gnt = gnt_valid & (winner == PORT_DBG);
    assign win_we  = (winner == PORT_CPU) ? cpu_we : dbg_we;

    // Steer the winner's access onto the RAM port; idle cycles drive a clean all-zero bus.
    always_comb begin
        ram_en    = gnt_valid;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt_valid) begin
            ram_we    = win_we;
            ram_addr  = (winner == PORT_CPU) ? cpu_addr  : dbg_addr;
            ram_wdata = (winner == PORT_CPU) ? cpu_wdata : dbg_wdata;
        end
    end

    // Next-state: remember the winner, track an outstanding read, count CPU stall cycles.
    always_comb begin
        last_winner_d = last_winner_q;
        rd_pending_d  = 1'b0;
        rd_owner_d    = rd_owner_q;
        wait_cnt_d    = wait_cnt_q;
        if (gnt_valid) begin
            last_winner_d = winner;
            if (!win_we) begin
                rd_pending_d = 1'b1;
                rd_owner_d   = winner;
            end
        end
        if (cpu_req && !cpu_gnt && !(&wait_cnt_q)) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
    end

    // State registers; reset makes the CPU win the first tie and drops any pending read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_winner_q <= PORT_DBG;
            rd_pending_q  <= 1'b0;
            rd_owner_q    <= PORT_CPU;
            wait_cnt_q    <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            rd_pending_q  <= rd_pending_d;
            rd_owner_q    <= rd_owner_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // The RAM returns data the cycle after the read; route it only to the port that issued it.
    assign cpu_rvalid   = rd_pending_q & (rd_owner_q == PORT_CPU);
    assign dbg_rvalid   = rd_pending_q & (rd_owner_q == PORT_DBG);
    assign cpu_rdata    = cpu_rvalid ? ram_rdata : '0;
    assign dbg_rdata    = dbg_rvalid ? ram_rdata : '0;
    assign cpu_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// tb/tb_mcpu_mem_arbiter.sv - self-checking bench for mcpu_mem_arbiter
module tb_mcpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0]  cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] cpu_wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tb_ram [256];
    logic [15:0] m_mem  [256];

    always #5 clk = ~clk;

    mcpu_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_lock     (dbg_lock),
        .dbg_gnt      (dbg_gnt),
        .dbg_rvalid   (dbg_rvalid),
        .dbg_rdata    (dbg_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .cpu_wait_cnt (cpu_wait_cnt)
    );

    // Synchronous single-port RAM seen by the arbiter.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tb_ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= tb_ram[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decides each cycle who must own the RAM and what each port must see.
    initial begin : model
        bit          m_last_dbg;
        bit          m_pend;
        bit          m_owner_dbg;
        logic [15:0] m_data;
        int          m_cnt;
        bit          ec, ed, any, win_dbg, we;
        logic [7:0]  a;
        logic [15:0] wd;
        m_last_dbg = 1'b1;
        m_pend = 1'b0;
        m_owner_dbg = 1'b0;
        m_data = '0;
        m_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_last_dbg = 1'b1;
                m_pend     = 1'b0;
                m_cnt      = 0;
                check("rst_cpu_gnt",    32'(cpu_gnt),      32'd0);
                check("rst_dbg_gnt",    32'(dbg_gnt),      32'd0);
                check("rst_cpu_rvalid", 32'(cpu_rvalid),   32'd0);
                check("rst_dbg_rvalid", 32'(dbg_rvalid),   32'd0);
                check("rst_cpu_rdata",  32'(cpu_rdata),    32'd0);
                check("rst_dbg_rdata",  32'(dbg_rdata),    32'd0);
                check("rst_ram_en",     32'(ram_en),       32'd0);
                check("rst_ram_we",     32'(ram_we),       32'd0);
                check("rst_wait_cnt",   32'(cpu_wait_cnt), 32'd0);
            end else begin
                ec  = cpu_req && !dbg_lock;
                ed  = dbg_req;
                any = ec || ed;
                win_dbg = (ec && ed) ? !m_last_dbg : ed;
                we  = win_dbg ? dbg_we    : cpu_we;
                a   = win_dbg ? dbg_addr  : cpu_addr;
                wd  = win_dbg ? dbg_wdata : cpu_wdata;

                check("cpu_gnt",    32'(cpu_gnt),    32'(any && !win_dbg));
                check("dbg_gnt",    32'(dbg_gnt),    32'(any && win_dbg));
                check("ram_en",     32'(ram_en),     32'(any));
                check("ram_we",     32'(ram_we),     32'(any && we));
                check("ram_addr",   32'(ram_addr),   any ? 32'(a)  : 32'd0);
                check("ram_wdata",  32'(ram_wdata),  any ? 32'(wd) : 32'd0);
                check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend && !m_owner_dbg));
                check("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pend && m_owner_dbg));
                check("cpu_rdata",  32'(cpu_rdata),  (m_pend && !m_owner_dbg) ? 32'(m_data) : 32'd0);
                check("dbg_rdata",  32'(dbg_rdata),  (m_pend && m_owner_dbg)  ? 32'(m_data) : 32'd0);
                check("wait_cnt",   32'(cpu_wait_cnt), 32'(m_cnt));

                m_pend = 1'b0;
                if (any) begin
                    m_last_dbg = win_dbg;
                    if (we) begin
                        m_mem[a] = wd;
                    end else begin
                        m_pend      = 1'b1;
                        m_owner_dbg = win_dbg;
                        m_data      = m_mem[a];
                    end
                end
                if (cpu_req && !(any && !win_dbg) && m_cnt < 65535) m_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                         input logic dr, input logic dw, input logic [7:0] da, input logic [15:0] dd,
                         input logic lk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        dbg_lock = lk;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    endtask

    task automatic reset_pulse();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin : stim
        for (int i = 0; i < 256; i++) begin
            tb_ram[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
            m_mem[i]  = 16'(i * 16'h0101) ^ 16'h5A5A;
        end
        tb_ram[5] = 16'h1234;
        m_mem[5]  = 16'h1234;
        ram_rdata = '0;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Uncontested CPU read after reset
        drive(1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
        #1;
        check("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("t1_dbg_gnt", 32'(dbg_gnt), 32'd0);
        tick();
        idle();
        #1;
        check("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("t1_cpu_rdata",  32'(cpu_rdata),  32'h1234);
        check("t1_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("t1_dbg_rdata",  32'(dbg_rdata),  32'd0);
        tick();

        // Full contention: grants alternate starting with the CPU
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + i), 16'h0000, 1'b1, 1'b0, 8'(8'h20 + i), 16'h0000, 1'b0);
            #1;
            check("t2_cpu_gnt", 32'(cpu_gnt), 32'((i % 2) == 0));
            check("t2_dbg_gnt", 32'(dbg_gnt), 32'((i % 2) == 1));
            tick();
        end
        idle();
        #1;
        check("t2_wait_cnt", 32'(cpu_wait_cnt), 32'd3);
        check("t2_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        tick();

        // Locked program load: DBG writes 0x00..0x1C while the CPU is held off
        reset_pulse();
        for (int a = 0; a <= 8'h1C; a++) begin
            drive(1'b1, 1'b0, 8'h07, 16'h0000, 1'b1, 1'b1, 8'(a), 16'h3013, 1'b1);
            #1;
            check("t3_dbg_gnt", 32'(dbg_gnt), 32'd1);
            check("t3_cpu_gnt", 32'(cpu_gnt), 32'd0);
            tick();
        end
        for (int a = 0; a <= 8'h1C; a++) begin
            check("t3_ram_word", 32'(tb_ram[a]), 32'h3013);
        end
        drive(1'b1, 1'b0, 8'h07, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
        #1;
        check("t3_unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("t3_wait_cnt",       32'(cpu_wait_cnt), 32'd29);
        tick();

        // Lock rising after a CPU read grant does not cancel its data
        drive(1'b1, 1'b0, 8'h08, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        #1;
        check("t4_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("t4_cpu_rdata",  32'(cpu_rdata),  32'h3013);
        check("t4_cpu_gnt",    32'(cpu_gnt),    32'd0);
        tick();
        idle();
        tick();

        // Reset right after a DBG read grant drops the pending data
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0);
        #1;
        check("t5_dbg_gnt", 32'(dbg_gnt), 32'd1);
        tick();
        idle();
        reset = 1'b1;
        #1;
        check("t5_dbg_rvalid_rst", 32'(dbg_rvalid), 32'd0);
        check("t5_ram_en_rst",     32'(ram_en),     32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("t5_dbg_rvalid_after", 32'(dbg_rvalid), 32'd0);
        check("t5_cpu_rvalid_after", 32'(cpu_rvalid), 32'd0);

        // Starve the CPU long enough to hit the counter ceiling
        reset_pulse();
        drive(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        for (int i = 0; i < 65534; i++) tick();
        check("t6_wait_cnt_fffe", 32'(cpu_wait_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) tick();
        check("t6_wait_cnt_sat", 32'(cpu_wait_cnt), 32'hFFFF);
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
